cbs1_window_feeder: RTL and testbench
=====================================

// Module: cbs1_window_feeder
// PURPOSE
// - Upstream stage of the three-channel CBS1 conv array: turns a raster stream of 3-channel 8-bit pixels into 3-row x 10-column windows, one per channel.
// - Each window is 240 bits per channel, matching the conv stage's data_in1..3 inputs. That stage makes 8 valid 3x3 outputs per window, so successive windows step 8 columns and overlap by 2.
// - Holds two previous rows in line buffers and a 10-deep column shift register for each of the 3 rows. Uses a valid/ready handshake on both sides.
// PARAMETERS
// - IMG_W   66  pixels per row; (IMG_W-2) must be a multiple of 8 (SVA check at elaboration)
// - IMG_H   66  rows per frame; must be >= 3
// - PIX_W   8   bits per pixel per channel
// PORTS
// - clk        in   1    system clock, all logic rising-edge
// - rst        in   1    asynchronous reset, active-low
// - in_valid   in   1    input pixel valid
// - in_ready   out  1    feeder can accept a pixel this cycle
// - in_pix     in   24   {ch3,ch2,ch1}; ch1 in bits [7:0]
// - out_valid  out  1    window valid
// - out_ready  in   1    downstream accepts window
// - data_out1  out  240  ch1 window
// - data_out2  out  240  ch2 window
// - data_out3  out  240  ch3 window
// - frame_done out  1    1-cycle pulse when the last window of a frame is accepted
// BEHAVIOUR
// - Window packing: data_outN[80*r + 8*k +: 8] = channel N pixel at (row top+r, col c0+k), with r=0..2 and k=0..9. Row 0 is the oldest row.
// - Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance on each accepted pixel (in_valid&&in_ready). col wraps to 0 at IMG_W-1, and row increments at that point.
// - Line buffers: 2-slot ring of IMG_W x 24-bit rows.
//   - The pixel at col is written into the slot for row-2, after that row's value at col has been read.
//   - Read-before-write is required in the same cycle.
// - FSM states:
//   - FILL: rows 0-1 are loaded and no windows are produced. Go to RUN on acceptance of pixel (row=1, col=IMG_W-1).
//   - RUN: a window is emitted when the accepted pixel has col>=9 and (col-9)%8==0. Go to FILL after pixel (IMG_H-1, IMG_W-1), with counters at 0 ready for the next frame.
// - Window emission: the window is registered on the cycle the completing pixel is accepted, so out_valid rises 1 cycle after acceptance (latency 1). Windows per row = (IMG_W-2)/8.
// - Handshake:
//   - Single output register.
//   - in_ready = !out_valid || out_ready.
//   - data_out and out_valid hold stable while out_valid && !out_ready.
//   - A simultaneous accept of the old window and a new completing pixel loads the new window with no bubble.
// - frame_done is asserted in the cycle the window from row IMG_H-1 at col IMG_W-1 is accepted.
// - Reset values: out_valid=0, frame_done=0, data_out*=0, counters=0, state=FILL, shift registers=0. Line-buffer RAM is not cleared.
// - Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as (0,0), and no window from stale line data is emitted before row 2.
// - in_valid=0 freezes all counters and shift registers. Pixels are never dropped or duplicated.
// CONFIGURATION
// - Macro: CBS1_FEED_STATS_EN
// - Defined:
//   - Adds outputs stall_cnt[31:0] (cycles with out_valid && !out_ready) and frame_cnt[15:0] (frame_done pulses).
//   - Both counters reset to 0 on rst and wrap on overflow.
// - Undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
// - Package cbs1_pkg holds:
//   - Constants: PIX_W=8, N_CH=3, K_ROWS=3, WIN_COLS=10, OUT_COLS=8, WIN_BITS=240.
//   - Typedefs: pix3_t (24-bit RGB pixel), win_t (240-bit window), feed_state_e {FILL, RUN}.
// - Sub-module cbs1_line_buf: simple dual-port RAM, depth IMG_W, width 24, synchronous read-before-write. Two instances or one 2-slot bank.
// - Top level: counters, FSM, 3x10x24-bit shift registers, output register, window-emit decode.
// TESTING
// - Ramp frame with IMG_W=IMG_H=10, pix(r,c)=r*16+c on all channels, out_ready=1. Expect exactly 8 windows. The first window has data_out1[7:0]=0x00 and [239:232]=0x29, and frame_done pulses once.
// - Same frame with out_ready low for 5 cycles during the first window. Expect data_out held, in_ready=0 for those cycles, no lost window, and identical window sequence.
// - IMG_W=18 with random in_valid gaps (~50%). Expect 2 windows per row starting at c0=0 and c0=8; the second window's k=0 pixel equals the first window's k=8 pixel.
// - Assert rst low mid-row 4, then send a fresh frame. Expect no window before the new frame's row 2 col 9, and correct contents thereafter.
// - Two back-to-back frames, with out_ready toggling each cycle and in_valid held continuously high. Expect in_ready to stall on every held window, 2x the per-frame window count with none lost or duplicated, and frame_done pulsing twice.
// - With CBS1_FEED_STATS_EN: hold out_ready=0 for 7 cycles. Expect stall_cnt=7 and frame_cnt=1 after one frame.

Source files
------------

// File: rtl/cbs1_pkg.sv
// cbs1_pkg: shared constants and types for the CBS1 window feeder
package cbs1_pkg;
  localparam int PIX_W    = 8;
  localparam int N_CH     = 3;
  localparam int K_ROWS   = 3;
  localparam int WIN_COLS = 10;
  localparam int OUT_COLS = 8;
  localparam int WIN_BITS = K_ROWS * WIN_COLS * PIX_W;
  typedef logic [N_CH*PIX_W-1:0] pix3_t;
  typedef logic [WIN_BITS-1:0] win_t;
  typedef enum logic {FILL, RUN} feed_state_e;
endpackage

// File: rtl/cbs1_line_buf.sv
// cbs1_line_buf: one row of pixels, dual-port RAM with registered read returning pre-write data
module cbs1_line_buf
  import cbs1_pkg::*;
#(
  parameter int DEPTH = 66,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pix3_t         wdata,
  input  logic [AW-1:0] raddr,
  output pix3_t         rdata
);
  pix3_t mem [DEPTH];
  // write and read on the same edge; a colliding read sees the old word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/cbs1_window_feeder.sv
// cbs1_window_feeder: raster 3-channel pixels to 3x10 windows; CBS1_FEED_STATS_EN adds stall/frame counters
module cbs1_window_feeder
  import cbs1_pkg::*;
#(
  parameter int IMG_W = 66,
  parameter int IMG_H = 66,
  parameter int PIX_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [23:0]  in_pix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [239:0] data_out1,
  output logic [239:0] data_out2,
  output logic [239:0] data_out3,
  output logic         frame_done
`ifdef CBS1_FEED_STATS_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [15:0]  frame_cnt
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  if ((IMG_W - 2) % OUT_COLS != 0) begin : g_chk_w
    $error("cbs1_window_feeder: IMG_W-2 must be a multiple of %0d", OUT_COLS);
  end
  if (IMG_H < 3) begin : g_chk_h
    $error("cbs1_window_feeder: IMG_H must be at least 3");
  end
  if (PIX_W != cbs1_pkg::PIX_W) begin : g_chk_p
    $error("cbs1_window_feeder: PIX_W must match cbs1_pkg");
  end
  logic [CW-1:0] col, col_nx, col_off, raddr;
  logic [RW-1:0] row, row_nx;
  feed_state_e state, state_nx;
  logic acc, col_end, row_end, emit_col, emit, last_q;
  pix3_t lb0_q, lb1_q, up2, up1;
  pix3_t [K_ROWS-1:0][WIN_COLS-1:0] sr, sr_nx;
  win_t w1, w2, w3;
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign col_end  = col == CW'(IMG_W - 1);
  assign row_end  = row == RW'(IMG_H - 1);
  assign col_nx   = col_end ? '0 : col + CW'(1);
  assign row_nx   = !col_end ? row : row_end ? '0 : row + RW'(1);
  assign col_off  = col - CW'(WIN_COLS - 1);
  assign emit_col = col >= CW'(WIN_COLS - 1) && (col_off % CW'(OUT_COLS)) == '0;
  assign emit     = acc && state == RUN && emit_col;
  assign frame_done = out_valid && out_ready && last_q;
  // prefetch the column the next accepted pixel will need, so its line data is ready on acceptance
  assign raddr = acc ? col_nx : col;
  // slot row[0] holds row-2 and is overwritten by the current row
  assign up2 = row[0] ? lb1_q : lb0_q;
  assign up1 = row[0] ? lb0_q : lb1_q;
  cbs1_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk(clk), .we(acc && !row[0]), .waddr(col), .wdata(in_pix), .raddr(raddr), .rdata(lb0_q)
  );
  cbs1_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk(clk), .we(acc && row[0]), .waddr(col), .wdata(in_pix), .raddr(raddr), .rdata(lb1_q)
  );
  // shift every row one column left and append the new column {row-2, row-1, incoming}
  always_comb begin
    sr_nx = sr;
    for (int r = 0; r < K_ROWS; r++)
      for (int k = 0; k < WIN_COLS - 1; k++)
        sr_nx[r][k] = sr[r][k+1];
    sr_nx[0][WIN_COLS-1] = up2;
    sr_nx[1][WIN_COLS-1] = up1;
    sr_nx[2][WIN_COLS-1] = in_pix;
  end
  // split the post-shift columns into one window per channel, oldest row and column at the LSBs
  always_comb begin
    w1 = '0;
    w2 = '0;
    w3 = '0;
    for (int r = 0; r < K_ROWS; r++)
      for (int k = 0; k < WIN_COLS; k++) begin
        w1[WIN_COLS*PIX_W*r + PIX_W*k +: PIX_W] = sr_nx[r][k][PIX_W-1:0];
        w2[WIN_COLS*PIX_W*r + PIX_W*k +: PIX_W] = sr_nx[r][k][2*PIX_W-1:PIX_W];
        w3[WIN_COLS*PIX_W*r + PIX_W*k +: PIX_W] = sr_nx[r][k][3*PIX_W-1:2*PIX_W];
      end
  end
  // leave FILL once two rows are buffered; return to FILL at the end of the frame
  always_comb begin
    state_nx = state;
    if (acc && col_end)
      state_nx = (state == FILL && row == RW'(1)) ? RUN : (state == RUN && row_end) ? FILL : state;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else state <= state_nx;
  end
  // raster position and column shift registers advance only on accepted pixels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
      sr  <= '0;
    end else if (acc) begin
      col <= col_nx;
      row <= row_nx;
      sr  <= sr_nx;
    end
  end
  // single output register: load on a completing pixel, otherwise drain when downstream takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      last_q    <= 1'b0;
      data_out1 <= '0;
      data_out2 <= '0;
      data_out3 <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      last_q    <= row_end && col_end;
      data_out1 <= w1;
      data_out2 <= w2;
      data_out3 <= w3;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef CBS1_FEED_STATS_EN
  // count held-window cycles and completed frames, wrapping on overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(out_valid && !out_ready);
      frame_cnt <= frame_cnt + 16'(frame_done);
    end
  end
`endif
endmodule

// File: tb/tb_cbs1_window_feeder.sv
// tb_cbs1_window_feeder: directed checks of window contents, handshake, frame_done and reset
module tb_cbs1_window_feeder;
  localparam int W = 18;
  localparam int H = 6;
  typedef struct {
    int top;
    int c0;
    logic [7:0] lo;
    logic [7:0] hi;
  } vec_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, frame_done;
  logic [23:0] in_pix;
  logic [239:0] data_out1, data_out2, data_out3;
`ifdef CBS1_FEED_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] frame_cnt;
`endif
  vec_t vt [8];
  logic [719:0] q [$];
  int fd_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;
  int rdy_mode = 0;
  cbs1_window_feeder #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .frame_done(frame_done)
`ifdef CBS1_FEED_STATS_EN
    , .stall_cnt(stall_cnt), .frame_cnt(frame_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [23:0] pix(input int r, input int c);
    logic [7:0] v;
    v = 8'(r * 16 + c);
    return {v ^ 8'hA5, ~v, v};
  endfunction
  function automatic logic [239:0] win(input int ch, input int top, input int c0);
    logic [239:0] w;
    logic [23:0] p;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 10; k++) begin
        p = pix(top + r, c0 + k);
        w[80*r + 8*k +: 8] = p[8*ch +: 8];
      end
    return w;
  endfunction
  task automatic check(input string nm, input logic [239:0] act, input logic [239:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ~out_ready;
  end
  always @(negedge clk) begin
    if (out_valid || frame_done)
      check("frame_done", 240'(frame_done), 240'(out_valid && out_ready && (q.size() % 8 == 7)));
    if (out_valid && !out_ready) check("held_in_ready", 240'(in_ready), 240'(0));
    if (out_valid && out_ready) q.push_back({data_out3, data_out2, data_out1});
    if (frame_done) fd_cnt++;
  end
  task automatic clear_sb();
    @(posedge clk);
    #1;
    q.delete();
    fd_cnt = 0;
  endtask
  task automatic drain();
    repeat (10) @(negedge clk);
  endtask
  task automatic send_pixels(input int n, input bit gaps);
    int idx, t, r, c, pr, pc;
    bit pend;
    idx = 0; t = 0; pr = 0; pc = 0; pend = 1'b0;
    while (idx < n && t < 20000) begin
      r = (idx / W) % H;
      c = idx % W;
      @(posedge clk);
      #1;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pix = pix(r, c);
      @(negedge clk);
      t++;
      if (pend) begin
        check("latency_valid", 240'(out_valid), 240'(1));
        check("latency_data", data_out1, win(0, pr - 2, pc - 9));
        pend = 1'b0;
      end
      if (in_valid && in_ready) begin
        pend = r >= 2 && c >= 9 && (c - 9) % 8 == 0;
        pr = r;
        pc = c;
        idx++;
      end
    end
    check("send_pixels_done", 240'(idx), 240'(n));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    if (pend) begin
      check("latency_valid", 240'(out_valid), 240'(1));
      check("latency_data", data_out1, win(0, pr - 2, pc - 9));
    end
  endtask
  task automatic stall_seq(input int n);
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("stall_wait_valid", 240'(out_valid), 240'(1));
    for (int i = 0; i < n; i++) begin
      check("stall_in_ready", 240'(in_ready), 240'(0));
      check("stall_valid", 240'(out_valid), 240'(1));
      check("stall_hold", data_out1, win(0, 0, 0));
      @(posedge clk);
      #1;
      if (i == n - 1) out_ready = 1'b1;
      @(negedge clk);
    end
  endtask
  task automatic check_windows(input string nm, input int nf);
    logic [719:0] w;
    check({nm, "_count"}, 240'(q.size()), 240'(8 * nf));
    check({nm, "_frame_done_cnt"}, 240'(fd_cnt), 240'(nf));
    foreach (q[i]) begin
      if (i < 8 * nf) begin
        w = q[i];
        check({nm, "_d1"}, w[239:0], win(0, vt[i%8].top, vt[i%8].c0));
        check({nm, "_d2"}, w[479:240], win(1, vt[i%8].top, vt[i%8].c0));
        check({nm, "_d3"}, w[719:480], win(2, vt[i%8].top, vt[i%8].c0));
        check({nm, "_lo"}, 240'(w[7:0]), 240'(vt[i%8].lo));
        check({nm, "_hi"}, 240'(w[239:232]), 240'(vt[i%8].hi));
      end
    end
  endtask
  initial begin
    vt[0] = '{top: 0, c0: 0, lo: 8'h00, hi: 8'h29};
    vt[1] = '{top: 0, c0: 8, lo: 8'h08, hi: 8'h31};
    vt[2] = '{top: 1, c0: 0, lo: 8'h10, hi: 8'h39};
    vt[3] = '{top: 1, c0: 8, lo: 8'h18, hi: 8'h41};
    vt[4] = '{top: 2, c0: 0, lo: 8'h20, hi: 8'h49};
    vt[5] = '{top: 2, c0: 8, lo: 8'h28, hi: 8'h51};
    vt[6] = '{top: 3, c0: 0, lo: 8'h30, hi: 8'h59};
    vt[7] = '{top: 3, c0: 8, lo: 8'h38, hi: 8'h61};
    rst = 1'b0;
    in_valid = 1'b0;
    in_pix = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 240'(out_valid), 240'(0));
    check("reset_frame_done", 240'(frame_done), 240'(0));
    check("reset_in_ready", 240'(in_ready), 240'(1));
    check("reset_data1", data_out1, '0);
    check("reset_data2", data_out2, '0);
    check("reset_data3", data_out3, '0);
    clear_sb();
    send_pixels(W * H, 1'b0);
    drain();
    check_windows("ramp", 1);
    clear_sb();
    rdy_mode = 3;
    out_ready = 1'b0;
    fork
      send_pixels(W * H, 1'b0);
      stall_seq(5);
    join
    drain();
    check_windows("stall", 1);
    rdy_mode = 0;
`ifdef CBS1_FEED_STATS_EN
    check("stats_stall_cnt", 240'(stall_cnt), 240'(5));
    check("stats_frame_cnt", 240'(frame_cnt), 240'(2));
`endif
    clear_sb();
    send_pixels(W * H, 1'b1);
    drain();
    check_windows("gaps", 1);
    clear_sb();
    send_pixels(4 * W + 5, 1'b0);
    drain();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_valid", 240'(out_valid), 240'(0));
    check("async_rst_data1", data_out1, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_sb();
    send_pixels(W * H, 1'b0);
    drain();
    check_windows("rst_mid", 1);
    clear_sb();
    rdy_mode = 1;
    send_pixels(2 * W * H, 1'b0);
    drain();
    check_windows("b2b", 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
